fpu_op_sequencer: RTL and testbench

Operand-issue and result-capture stage wrapped around the fpu core (1-bit sign, 6-bit exponent, 25-bit mantissa). It accepts operand pairs through a valid/ready FIFO and holds each pair stable on the fpu inputs for a fixed settle window. It then samples data_out/status_out into a result register with a valid/ready handshake, and keeps sticky exception flags. Because the fpu has no done signal, this stage replaces the fixed-delay waiting done by the bench.

---
 rtl/fpu_pkg.sv | 24 ++
 rtl/fpu_op_fifo.sv | 59 +++++
 rtl/fpu_op_sequencer.sv | 138 +++++++++++++
 tb/tb_fpu_op_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared definitions for the fpu operand sequencer.
//   Format constants for the fpu word (sign, exponent, mantissa, status).
//   seq_state_t : issue/wait/capture FSM states.
//   op_pair_t   : one operand pair as stored in the operand FIFO.
package fpu_pkg;

   localparam int unsigned SIGN_BIT = 31;
   localparam int unsigned EXP_W    = 6;
   localparam int unsigned MANT_W   = 25;
   localparam int unsigned WORD_W   = 32;
   localparam int unsigned STATUS_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_OUT  = 2'd2
   } seq_state_t;

   typedef struct packed {
      logic [WORD_W-1:0] a;
      logic [WORD_W-1:0] b;
   } op_pair_t;

endpackage

// File: rtl/fpu_op_fifo.sv
// Synchronous FIFO of operand pairs.
//   clk, rst    : clock, asynchronous active-high reset
//   push, din   : write request and data (ignored when full, even with a pop)
//   pop, dout   : read request; dout shows the head entry combinationally
//   full, empty : occupancy flags derived from count
//   count       : number of stored entries
module fpu_op_fifo
   import fpu_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  op_pair_t         din,
   input  logic             pop,
   output op_pair_t         dout,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   op_pair_t mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic push_ok;
   logic pop_ok;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Pointers wrap naturally at DEPTH (power of two)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset; only entries behind count are ever read
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/fpu_op_sequencer.sv
// Operand-issue and result-capture stage around the fpu core.
// Queues operand pairs, holds each one on the fpu inputs for WAIT_CYCLES,
// then captures the fpu result/status and offers it on a valid/ready port.
//   clock100KHz, reset           : clock, asynchronous active-high reset
//   in_valid/in_ready/in_a/in_b  : operand pair input handshake
//   op_A_out/op_B_out            : registered operands to the fpu
//   fpu_data_in/fpu_status_in    : fpu result and status
//   res_valid/res_ready          : result handshake
//   res_data/res_status          : captured result and status
//   sticky_status/sticky_clr     : accumulated status flags and their clear
//   busy                         : operation in flight or operands queued
module fpu_op_sequencer
   import fpu_pkg::*;
#(
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned WAIT_CYCLES = 64,
   parameter int unsigned WIDTH       = 32
) (
   input  logic                clock100KHz,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WIDTH-1:0]    in_a,
   input  logic [WIDTH-1:0]    in_b,
   output logic [WIDTH-1:0]    op_A_out,
   output logic [WIDTH-1:0]    op_B_out,
   input  logic [WIDTH-1:0]    fpu_data_in,
   input  logic [STATUS_W-1:0] fpu_status_in,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [WIDTH-1:0]    res_data,
   output logic [STATUS_W-1:0] res_status,
   output logic [STATUS_W-1:0] sticky_status,
   input  logic                sticky_clr,
   output logic                busy
);

   localparam int unsigned CNT_W  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam int unsigned FCNT_W = $clog2(DEPTH) + 1;

   seq_state_t state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0]    op_a_d, op_b_d, res_data_d;
   logic [STATUS_W-1:0] res_status_d, sticky_d;
   logic                res_valid_d;
   logic                pop_c;
   logic                capture_c;

   op_pair_t            fifo_din, fifo_dout;
   logic                fifo_full, fifo_empty;
   logic [FCNT_W-1:0]   fifo_count;

   assign fifo_din = '{a: WORD_W'(in_a), b: WORD_W'(in_b)};
   assign in_ready = !fifo_full;
   assign busy     = (state_q != ST_IDLE) || (fifo_count != '0);

   fpu_op_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clock100KHz),
      .rst   (reset),
      .push  (in_valid),
      .din   (fifo_din),
      .pop   (pop_c),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Next-state, operand issue, capture and sticky update
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      op_a_d       = op_A_out;
      op_b_d       = op_B_out;
      res_data_d   = res_data;
      res_status_d = res_status;
      res_valid_d  = res_valid;
      pop_c        = 1'b0;
      capture_c    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop_c   = 1'b1;
               op_a_d  = WIDTH'(fifo_dout.a);
               op_b_d  = WIDTH'(fifo_dout.b);
               cnt_d   = CNT_W'(WAIT_CYCLES - 1);
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               capture_c    = 1'b1;
               res_data_d   = fpu_data_in;
               res_status_d = fpu_status_in;
               res_valid_d  = 1'b1;
               state_d      = ST_OUT;
            end
         end
         ST_OUT: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Clear takes effect before a same-edge capture sets new flags
      sticky_d = sticky_clr ? '0 : sticky_status;
      if (capture_c) sticky_d = sticky_d | fpu_status_in;
   end

   always_ff @(posedge clock100KHz or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         op_A_out      <= '0;
         op_B_out      <= '0;
         res_data      <= '0;
         res_status    <= '0;
         res_valid     <= 1'b0;
         sticky_status <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         op_A_out      <= op_a_d;
         op_B_out      <= op_b_d;
         res_data      <= res_data_d;
         res_status    <= res_status_d;
         res_valid     <= res_valid_d;
         sticky_status <= sticky_d;
      end
   end

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Self-checking bench for fpu_op_sequencer with an fpu stub that either
// returns a programmed data/status pair or a fixed function of its operands.
module tb_fpu_op_sequencer;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned WAIT_CYCLES = 64;
   localparam int unsigned WIDTH = 32;

   logic             clock100KHz = 1'b0;
   logic             reset = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_a = '0;
   logic [WIDTH-1:0] in_b = '0;
   logic [WIDTH-1:0] op_A_out, op_B_out;
   logic [WIDTH-1:0] fpu_data_in;
   logic [3:0]       fpu_status_in;
   logic             res_valid;
   logic             res_ready = 1'b0;
   logic [WIDTH-1:0] res_data;
   logic [3:0]       res_status;
   logic [3:0]       sticky_status;
   logic             sticky_clr = 1'b0;
   logic             busy;

   logic             prog_en = 1'b1;
   logic [31:0]      prog_data = '0;
   logic [3:0]       prog_status = '0;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
   } pair_t;
   pair_t exp_q[$];
   logic [3:0] sticky_m;

   fpu_op_sequencer #(.DEPTH(DEPTH), .WAIT_CYCLES(WAIT_CYCLES), .WIDTH(WIDTH)) dut (
      .clock100KHz   (clock100KHz),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_a          (in_a),
      .in_b          (in_b),
      .op_A_out      (op_A_out),
      .op_B_out      (op_B_out),
      .fpu_data_in   (fpu_data_in),
      .fpu_status_in (fpu_status_in),
      .res_valid     (res_valid),
      .res_ready     (res_ready),
      .res_data      (res_data),
      .res_status    (res_status),
      .sticky_status (sticky_status),
      .sticky_clr    (sticky_clr),
      .busy          (busy)
   );

   always #5 clock100KHz = ~clock100KHz;

   function automatic logic [31:0] stub_data(input logic [31:0] a, input logic [31:0] b);
      return (a ^ {b[15:0], b[31:16]}) + 32'h0000_1357;
   endfunction

   function automatic logic [3:0] stub_status(input logic [31:0] a, input logic [31:0] b);
      return a[3:0] ^ b[31:28];
   endfunction

   // fpu stand-in: combinational response to the operands the DUT presents
   always_comb begin
      fpu_data_in   = prog_en ? prog_data   : stub_data(op_A_out, op_B_out);
      fpu_status_in = prog_en ? prog_status : stub_status(op_A_out, op_B_out);
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One isolated operation with a programmed stub result; lat = edges from push to res_valid
   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] d,
                        input logic [3:0] st, input bit clr_on_capture, output int lat);
      @(negedge clock100KHz);
      prog_en = 1'b1; prog_data = d; prog_status = st;
      in_a = a; in_b = b; in_valid = 1'b1;
      lat = -1;
      for (int e = 0; e < 300; e++) begin
         @(negedge clock100KHz);
         in_valid = 1'b0;
         sticky_clr = 1'b0;
         if (e == 1) begin
            chk("issue_a", op_A_out, a);
            chk("issue_b", op_B_out, b);
         end
         if (res_valid) begin
            lat = e;
            break;
         end
         if (clr_on_capture && e == int'(WAIT_CYCLES)) sticky_clr = 1'b1;
      end
      sticky_clr = 1'b0;
      if (lat < 0) chk("op_timeout", 1, 0);
   endtask

   task automatic accept_one();
      res_ready = 1'b1;
      @(negedge clock100KHz);
      res_ready = 1'b0;
   endtask

   // Random producer/consumer against the expected-order queue and sticky model
   task automatic run_traffic(input int n_new, input int push_pct, input int ready_pct);
      int pushed = 0;
      bit last_valid = 1'b0;
      bit last_acc = 1'b0;
      logic [31:0] last_data = '0;
      bit done = 1'b0;
      pair_t p;
      prog_en = 1'b0;
      for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
         @(negedge clock100KHz);
         res_ready = 1'b0;
         in_valid = 1'b0;
         if (res_valid && last_valid && !last_acc) chk("hold", res_data, last_data);
         last_acc = 1'b0;
         if (res_valid && ($urandom_range(99) < ready_pct)) begin
            if (exp_q.size() == 0) begin
               chk("extra_result", 1, 0);
            end else begin
               p = exp_q.pop_front();
               chk("res_data", res_data, stub_data(p.a, p.b));
               chk("res_status", res_status, stub_status(p.a, p.b));
               sticky_m = sticky_m | stub_status(p.a, p.b);
               chk("sticky", sticky_status, sticky_m);
            end
            res_ready = 1'b1;
            last_acc = 1'b1;
         end
         last_valid = res_valid;
         last_data = res_data;
         if (pushed < n_new && ($urandom_range(99) < push_pct)) begin
            in_a = $urandom; in_b = $urandom; in_valid = 1'b1;
            if (in_ready) begin
               p.a = in_a; p.b = in_b;
               exp_q.push_back(p);
               pushed++;
            end
         end
         if (pushed == n_new && exp_q.size() == 0 && last_acc) done = 1'b1;
      end
      @(negedge clock100KHz);
      res_ready = 1'b0; in_valid = 1'b0;
      if (!done) chk("traffic_timeout", exp_q.size(), 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int times[$];
      int acc;
      int vcount;
      pair_t p;

      // Reset values while reset is held
      #2;
      chk("rst_op_a", op_A_out, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_busy", busy, 0);
      repeat (2) @(negedge clock100KHz);
      reset = 1'b0;

      // Single operation with exact latency
      do_op(32'h3E00_0000, 32'h3E00_0000, 32'h4000_0000, 4'b0001, 1'b0, lat);
      chk("single_lat", lat, WAIT_CYCLES + 1);
      chk("single_data", res_data, 32'h4000_0000);
      chk("single_status", res_status, 4'b0001);
      chk("single_sticky", sticky_status, 4'b0001);
      accept_one();
      chk("after_acc_valid", res_valid, 0);
      chk("after_acc_data", res_data, 32'h4000_0000);
      chk("after_acc_busy", busy, 0);

      // Sticky accumulate, then clear coinciding with a capture
      sticky_clr = 1'b1;
      @(negedge clock100KHz);
      sticky_clr = 1'b0;
      chk("sticky_clr_alone", sticky_status, 0);
      do_op(32'h1111_1111, 32'h2222_2222, 32'hAAAA_0001, 4'b0010, 1'b0, lat);
      chk("sticky1", sticky_status, 4'b0010);
      accept_one();
      do_op(32'h3333_3333, 32'h4444_4444, 32'hAAAA_0002, 4'b1000, 1'b0, lat);
      chk("sticky2", sticky_status, 4'b1010);
      accept_one();
      do_op(32'h5555_5555, 32'h6666_6666, 32'hAAAA_0003, 4'b0100, 1'b1, lat);
      chk("sticky3", sticky_status, 4'b0100);
      chk("sticky3_lat", lat, WAIT_CYCLES + 1);
      accept_one();

      // Asynchronous reset mid-cycle clears everything immediately
      @(negedge clock100KHz);
      in_a = 32'hDEAD_BEEF; in_b = 32'h0BAD_F00D; in_valid = 1'b1;
      @(negedge clock100KHz);
      in_valid = 1'b0;
      repeat (3) @(negedge clock100KHz);
      @(posedge clock100KHz);
      #2 reset = 1'b1;
      #1;
      chk("async_op_a", op_A_out, 0);
      chk("async_op_b", op_B_out, 0);
      chk("async_sticky", sticky_status, 0);
      chk("async_res_data", res_data, 0);
      chk("async_in_ready", in_ready, 1);
      chk("async_busy", busy, 0);
      @(negedge clock100KHz);
      reset = 1'b0;

      // Reset during WAIT with a second pair queued: nothing emerges afterwards
      prog_en = 1'b0;
      @(negedge clock100KHz);
      in_a = 32'h0102_0304; in_b = 32'h0506_0708; in_valid = 1'b1;
      @(negedge clock100KHz);
      in_a = 32'h1112_1314; in_b = 32'h1516_1718;
      @(negedge clock100KHz);
      in_valid = 1'b0;
      repeat (29) @(negedge clock100KHz);
      #2 reset = 1'b1;
      @(negedge clock100KHz);
      @(negedge clock100KHz);
      reset = 1'b0;
      res_ready = 1'b1;
      vcount = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clock100KHz);
         if (res_valid) vcount++;
      end
      res_ready = 1'b0;
      chk("midwait_no_result", vcount, 0);
      chk("midwait_busy", busy, 0);
      chk("midwait_in_ready", in_ready, 1);

      // Back-pressure: fill until refused, then drain in order
      sticky_clr = 1'b1;
      @(negedge clock100KHz);
      sticky_clr = 1'b0;
      sticky_m = '0;
      prog_en = 1'b0;
      acc = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock100KHz);
         in_valid = 1'b0;
         if (!in_ready) break;
         case (i)
            0:       begin in_a = 32'h3E00_0000; in_b = 32'hBE00_0000; end
            1:       begin in_a = 32'h6400_0064; in_b = 32'h1400_0064; end
            default: begin in_a = 32'hC000_0000 + 32'(i); in_b = 32'h4100_0000 + 32'(i * 3); end
         endcase
         in_valid = 1'b1;
         p.a = in_a; p.b = in_b;
         exp_q.push_back(p);
         acc++;
      end
      in_valid = 1'b0;
      chk("bp_accepted", acc, DEPTH + 1);
      repeat (80) @(negedge clock100KHz);
      chk("bp_still_full", in_ready, 0);
      chk("bp_valid_held", res_valid, 1);
      run_traffic(0, 0, 40);

      // Streaming with res_ready tied high
      prog_en = 1'b0;
      res_ready = 1'b1;
      @(negedge clock100KHz);
      for (int i = 0; i < 3; i++) begin
         in_a = $urandom; in_b = $urandom; in_valid = 1'b1;
         p.a = in_a; p.b = in_b;
         exp_q.push_back(p);
         @(negedge clock100KHz);
         if (i == 0) begin
            // first negedge after the first push edge is edge index 0
            times.delete();
         end
      end
      in_valid = 1'b0;
      // current negedge is edge index 2 relative to the first push
      for (int e = 3; e < 300; e++) begin
         @(negedge clock100KHz);
         if (res_valid) begin
            times.push_back(e);
            p = exp_q.pop_front();
            chk("stream_data", res_data, stub_data(p.a, p.b));
         end
      end
      res_ready = 1'b0;
      chk("stream_count", times.size(), 3);
      if (times.size() == 3) begin
         chk("stream_t0", times[0], WAIT_CYCLES + 1);
         chk("stream_t1", times[1], 2 * WAIT_CYCLES + 3);
         chk("stream_t2", times[2], 3 * WAIT_CYCLES + 5);
      end
      exp_q.delete();

      // Randomised traffic
      sticky_clr = 1'b1;
      @(negedge clock100KHz);
      sticky_clr = 1'b0;
      sticky_m = '0;
      run_traffic(20, 60, 50);
      chk("final_busy", busy, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
